// File: rtl/cpu_mem_dumper.sv
// Streams a range of the CPU's synchronous-read memory out over valid/ready,
// one word every REQ -> WAIT -> SEND pass, tagging each word with its address.
module cpu_mem_dumper #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              cpuClk,
  input  logic              cpuRst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic [ADDR_W-1:0] count,
  input  logic              wm,
  output logic              memRdEn,
  output logic [ADDR_W-1:0] memAddr,
  input  logic [DATA_W-1:0] memRdata,
  output logic              dumpValid,
  input  logic              dumpReady,
  output logic [ADDR_W-1:0] dumpAddr,
  output logic [DATA_W-1:0] dumpData,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_e;

  // count==0 encodes a full sweep, so rem needs one bit more than an address.
  localparam logic [ADDR_W:0]   REM_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [ADDR_W-1:0]   dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;
  logic                mem_rd_en;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cur_d       = cur_q;
    rem_d       = rem_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    mem_rd_en   = 1'b0;

    if (abort && state_q != S_IDLE) begin
      // Abort outranks a same-cycle handshake: the pending word is dropped.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cur_d   = startAddr;
            rem_d   = (count == '0) ? REM_FULL : {1'b0, count};
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          if (!wm) begin
            mem_rd_en = 1'b1;
            state_d   = S_WAIT;
          end
        end
        S_WAIT: begin
          dump_data_d = memRdata;
          dump_addr_d = cur_q;
          state_d     = S_SEND;
        end
        S_SEND: begin
          if (dumpReady) begin
            rem_d   = rem_q - REM_ONE;
            cur_d   = cur_q + ADDR_ONE;
            state_d = (rem_q > REM_ONE) ? S_REQ : S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge cpuClk or negedge cpuRst) begin
    if (!cpuRst) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      rem_q       <= '0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rem_q       <= rem_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
    end
  end

  assign memRdEn   = mem_rd_en;
  assign memAddr   = cur_q;
  assign dumpValid = (state_q == S_SEND);
  assign dumpAddr  = dump_addr_q;
  assign dumpData  = dump_data_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_cpu_mem_dumper.sv
// Self-checking bench for cpu_mem_dumper: a memory model feeds the read port and
// each dump is compared against the address/data sequence the range implies.
module tb_cpu_mem_dumper;

  logic        cpuClk;
  logic        cpuRst;
  logic        start;
  logic        abort;
  logic [4:0]  startAddr;
  logic [4:0]  count;
  logic        wm;
  logic        memRdEn;
  logic [4:0]  memAddr;
  logic [15:0] memRdata;
  logic        dumpValid;
  logic        dumpReady;
  logic [4:0]  dumpAddr;
  logic [15:0] dumpData;
  logic        busy;
  logic        done;

  logic [15:0] mem [32];

  int n_pass  = 0;
  int n_total = 0;

  cpu_mem_dumper #(.DATA_W(16), .ADDR_W(5)) dut (
    .cpuClk    (cpuClk),
    .cpuRst    (cpuRst),
    .start     (start),
    .abort     (abort),
    .startAddr (startAddr),
    .count     (count),
    .wm        (wm),
    .memRdEn   (memRdEn),
    .memAddr   (memAddr),
    .memRdata  (memRdata),
    .dumpValid (dumpValid),
    .dumpReady (dumpReady),
    .dumpAddr  (dumpAddr),
    .dumpData  (dumpData),
    .busy      (busy),
    .done      (done)
  );

  initial cpuClk = 1'b0;
  always #5 cpuClk = ~cpuClk;

  // Synchronous-read memory: data appears the cycle after the strobe.
  initial memRdata = '0;
  always @(posedge cpuClk) if (memRdEn) memRdata <= mem[memAddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One complete dump with optional disturbances; expectations come from the
  // range rule: word i is mem[(sa+i) mod 32], n = (cnt==0) ? 32 : cnt.
  task automatic do_dump(input int sa, input int cnt, input int rdy_pct, input int wm_pct,
                         input int rdy_hold_word, input int wm_burst_word,
                         input int abort_word, input int rst_word,
                         input bit stray, input bit exact);
    int n;
    int accepted;
    int rd_cnt;
    int first_valid;
    int first_rd;
    int rdy_hold;
    int wm_hold;
    int exp_addr;
    bit prev_stall;
    bit finished;
    logic [4:0]  prev_addr;
    logic [15:0] prev_data;
    n = (cnt == 0) ? 32 : cnt;
    accepted = 0; rd_cnt = 0; first_valid = -1; first_rd = -1;
    rdy_hold = 5; wm_hold = 0; prev_stall = 0; finished = 0;
    prev_addr = '0; prev_data = '0;

    start = 1'b1; startAddr = 5'(sa); count = 5'(cnt);
    abort = stray; wm = 1'b0; dumpReady = 1'b0;

    for (int c = 0; c < 3000 && !finished; c++) begin
      @(posedge cpuClk); #1;
      start     = stray ? 1'($urandom_range(1)) : 1'b0;
      startAddr = 5'($urandom);
      count     = 5'($urandom);
      abort     = (abort_word == accepted) && dumpValid;
      if (wm_hold > 0) begin
        wm = 1'b1;
        wm_hold--;
      end else begin
        wm = ($urandom_range(99) < wm_pct);
      end
      if (dumpValid && accepted == rdy_hold_word && rdy_hold > 0) begin
        dumpReady = 1'b0;
        rdy_hold--;
      end else begin
        dumpReady = ($urandom_range(99) < rdy_pct);
      end
      #1;
      exp_addr = (sa + accepted) % 32;

      if (rst_word == accepted && dumpValid) begin
        cpuRst = 1'b0; start = 1'b0; abort = 1'b0;
        #1;
        check("reset_async_outputs",
              {2'b0, memRdEn, memAddr, dumpValid, dumpAddr, dumpData, busy, done}, 32'h0);
        @(posedge cpuClk); #1;
        cpuRst = 1'b1;
        check("reset_idle_busy", busy, 1'b0);
        finished = 1;
      end else begin
        if (prev_stall) begin
          check("stall_valid", dumpValid, 1'b1);
          check("stall_addr", dumpAddr, prev_addr);
          check("stall_data", dumpData, prev_data);
        end
        if (wm) check("rden_blocked_by_wm", memRdEn, 1'b0);
        if (memRdEn) begin
          if (first_rd < 0) first_rd = c;
          check("rd_addr", memAddr, exp_addr);
          rd_cnt++;
        end
        if (dumpValid && first_valid < 0) first_valid = c;
        prev_stall = dumpValid && !dumpReady && !abort;
        prev_addr  = dumpAddr;
        prev_data  = dumpData;

        if (abort) begin
          @(posedge cpuClk); #1;
          start = 1'b0; abort = 1'b0;
          check("abort_idle", {dumpValid, busy, done}, 3'b000);
          finished = 1;
        end else if (dumpValid && dumpReady) begin
          check("dump_addr", dumpAddr, exp_addr);
          check("dump_data", dumpData, mem[exp_addr]);
          accepted++;
          if (accepted == wm_burst_word) wm_hold = 4;
        end else if (done) begin
          check("done_word_count", accepted, n);
          check("rd_count", rd_cnt, n);
          if (exact) begin
            check("first_rden_cycle", first_rd, 0);
            check("first_valid_cycle", first_valid, 2);
            check("done_cycle", c, 3 * n);
          end
          @(posedge cpuClk); #1;
          start = 1'b0;
          check("post_done_idle", {busy, done}, 2'b00);
          finished = 1;
        end
      end
    end
    if (!finished) check("dump_timeout", 1'b0, 1'b1);
    start = 1'b0; abort = 1'b0; wm = 1'b0; dumpReady = 1'b0;
  endtask

  initial begin
    cpuRst = 1'b0; start = 1'b0; abort = 1'b0; startAddr = '0; count = '0;
    wm = 1'b0; dumpReady = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'(i * 3);

    @(posedge cpuClk); @(posedge cpuClk); #1;
    check("reset_outputs",
          {2'b0, memRdEn, memAddr, dumpValid, dumpAddr, dumpData, busy, done}, 32'h0);
    cpuRst = 1'b1;
    // abort alone in IDLE does nothing
    abort = 1'b1;
    @(posedge cpuClk); #1;
    abort = 1'b0;
    check("abort_in_idle", busy, 1'b0);

    // Basic dump, exact latency and throughput
    do_dump(0, 4, 100, 0, -1, -1, -1, -1, 0, 1);
    // Address wrap
    do_dump(30, 4, 100, 0, -1, -1, -1, -1, 0, 1);
    // count 0 = full sweep
    do_dump(7, 0, 100, 0, -1, -1, -1, -1, 0, 1);
    // Back-pressure on word 2
    do_dump(3, 6, 100, 0, 2, -1, -1, -1, 0, 0);
    // Write mode held in REQ
    do_dump(10, 5, 100, 0, -1, 2, -1, -1, 0, 0);
    // Abort during word 1, then a clean dump
    do_dump(0, 8, 100, 0, -1, -1, 1, -1, 0, 0);
    do_dump(5, 3, 100, 0, -1, -1, -1, -1, 0, 1);
    // Reset mid-dump, then a clean dump
    do_dump(12, 6, 100, 0, -1, -1, -1, 2, 0, 0);
    do_dump(20, 5, 100, 0, -1, -1, -1, -1, 0, 1);

    // Randomized contents, ranges, back-pressure, write mode and stray starts
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    for (int t = 0; t < 8; t++) begin
      do_dump(int'($urandom_range(31)), int'($urandom_range(31)), 60, 25,
              -1, -1, -1, -1, 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
